layer_header_sequencer: RTL and testbench



---
 rtl/gpu_cmd_pkg.sv | 21 ++
 rtl/layer_header_sequencer_if.sv | 26 ++
 rtl/layer_hdr_port_arb.sv | 47 ++++
 rtl/layer_header_sequencer.sv | 133 +++++++++++++
 tb/tb_layer_header_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_cmd_pkg.sv
// Shared GPU command-decode definitions: opcodes, field positions, sequencer states.
package gpu_cmd_pkg;

  localparam logic [4:0] OP_RST_ALL_MEM = 5'b11000;
  localparam logic [4:0] OP_RST_LAYERS  = 5'b11001;
  localparam logic [4:0] OP_WR_LAYER    = 5'b10001;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 11;
  localparam int LAYER_MSB = 8;
  localparam int LAYER_LSB = 6;
  localparam int ALL_BIT   = 5;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR,
    DONE
  } seq_state_e;

endpackage

// File: rtl/layer_header_sequencer_if.sv
// Layer header RAM port: single-port, one-cycle read latency.
interface layer_header_sequencer_if #(
  parameter int HDR_W = 32
);
  logic             mem_en;
  logic             mem_we;
  logic [2:0]       mem_addr;
  logic [HDR_W-1:0] mem_wdata;
  logic [HDR_W-1:0] mem_rdata;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/layer_hdr_port_arb.sv
// RAM port arbiter: renderer reads win, but a pending command write is forced
// through after STARVE_MAX consecutive read grants.
module layer_hdr_port_arb #(
  parameter int HDR_W      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_pend,
  input  logic [2:0]                wr_addr,
  input  logic [HDR_W-1:0]          wr_data,
  input  logic                      rd_req,
  input  logic [2:0]                rd_layer,
  output logic                      rd_gnt,
  output logic                      wr_issue,
  layer_header_sequencer_if.master  mem
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;

  // Grant decision, starve counter update and RAM port mux.
  always_comb begin
    rd_gnt        = rd_req && (starve_cnt_q < STARVE_LIM);
    wr_issue      = wr_pend && !rd_gnt;
    starve_cnt_d  = '0;
    if (wr_pend && rd_gnt) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
    mem.mem_en    = rd_gnt || wr_issue;
    mem.mem_we    = wr_issue;
    mem.mem_addr  = wr_issue ? wr_addr : rd_layer;
    mem.mem_wdata = wr_issue ? wr_data : '0;
  end

  // Starve counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/layer_header_sequencer.sv
// Layer header command sequencer: decodes write/clear/clear-all commands and
// drives the header RAM through the shared port arbiter.
module layer_header_sequencer
  import gpu_cmd_pkg::*;
#(
  parameter int               HDR_W      = 32,
  parameter logic [HDR_W-1:0] CLEAR_VAL  = '0,
  parameter int               STARVE_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [15:0]               cmd_word,
  input  logic [HDR_W-1:0]          cmd_data,
  input  logic                      rd_req,
  input  logic [2:0]                rd_layer,
  output logic                      rd_gnt,
  output logic                      rd_valid,
  output logic [HDR_W-1:0]          rd_data,
  output logic                      busy,
  output logic                      done,
  output logic                      cmd_ignored,
  layer_header_sequencer_if.master  mem
);

  seq_state_e       state_q, state_d;
  logic [2:0]       layer_q, layer_d;
  logic [HDR_W-1:0] data_q, data_d;
  logic [2:0]       clr_cnt_q, clr_cnt_d;
  logic             ign_q, ign_d;
  logic             rd_valid_q;

  logic             accept;
  logic             wr_pend;
  logic             wr_issue;
  logic [2:0]       wr_addr;
  logic [HDR_W-1:0] wr_data;
  logic             unused_cmd_bits;

  assign unused_cmd_bits = ^{cmd_word[10:9], cmd_word[4:0]};

  assign cmd_ready   = (state_q == IDLE) || (state_q == DONE);
  assign busy        = (state_q == WRITE) || (state_q == CLEAR);
  assign done        = (state_q == DONE);
  assign cmd_ignored = ign_q;
  assign accept      = cmd_valid && cmd_ready;
  assign wr_pend     = busy;
  assign wr_addr     = (state_q == CLEAR) ? clr_cnt_q : layer_q;
  assign wr_data     = (state_q == CLEAR) ? CLEAR_VAL : data_q;
  assign rd_valid    = rd_valid_q;
  // RAM output is already the registered read result; mask it outside rd_valid.
  assign rd_data     = rd_valid_q ? mem.mem_rdata : '0;

  layer_hdr_port_arb #(
    .HDR_W      (HDR_W),
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_pend  (wr_pend),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_layer (rd_layer),
    .rd_gnt   (rd_gnt),
    .wr_issue (wr_issue),
    .mem      (mem)
  );

  // Next-state: progress current operation, then decode a newly accepted command.
  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    data_d    = data_q;
    clr_cnt_d = clr_cnt_q;
    ign_d     = 1'b0;
    case (state_q)
      WRITE: if (wr_issue) state_d = DONE;
      CLEAR: begin
        if (wr_issue) begin
          if (clr_cnt_q == 3'd7) state_d = DONE;
          else                   clr_cnt_d = clr_cnt_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      layer_d   = cmd_word[LAYER_MSB:LAYER_LSB];
      clr_cnt_d = '0;
      case (cmd_word[OP_MSB:OP_LSB])
        OP_RST_ALL_MEM: state_d = CLEAR;
        OP_RST_LAYERS: begin
          if (cmd_word[ALL_BIT]) begin
            state_d = CLEAR;
          end else begin
            state_d = WRITE;
            data_d  = CLEAR_VAL;
          end
        end
        OP_WR_LAYER: begin
          state_d = WRITE;
          data_d  = cmd_data;
        end
        default: begin
          state_d = IDLE;
          ign_d   = 1'b1;
        end
      endcase
    end
  end

  // Sequencer registers and read-valid pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      layer_q    <= '0;
      data_q     <= '0;
      clr_cnt_q  <= '0;
      ign_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      data_q     <= data_d;
      clr_cnt_q  <= clr_cnt_d;
      ign_q      <= ign_d;
      rd_valid_q <= rd_gnt;
    end
  end

endmodule

// File: tb/tb_layer_header_sequencer.sv
// Testbench for layer_header_sequencer with behavioural RAM and reference model.
module tb_layer_header_sequencer;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_word = '0;
  logic [31:0] cmd_data = '0;
  logic        rd_req = 1'b0;
  logic [2:0]  rd_layer = '0;
  logic        rd_gnt, rd_valid, busy, done, cmd_ignored;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  layer_header_sequencer_if #(.HDR_W(32)) mif ();

  layer_header_sequencer #(
    .HDR_W(32), .CLEAR_VAL(32'h0), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_word(cmd_word), .cmd_data(cmd_data), .rd_req(rd_req), .rd_layer(rd_layer),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .done(done), .cmd_ignored(cmd_ignored), .mem(mif)
  );

  // Single-port RAM, registered read output.
  logic [31:0] ram [8];
  always @(posedge clk) begin
    if (mif.mem_en) begin
      if (mif.mem_we) ram[mif.mem_addr] <= mif.mem_wdata;
      else            mif.mem_rdata <= ram[mif.mem_addr];
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_mem [8];

  int          wq_addr [$];
  logic [31:0] wq_data [$];
  int          wq_cyc  [$];
  int done_cyc, done_cnt, ign_cyc, ign_cnt, busy_bad, busy_hi, ready_lo;
  int mem_en_cnt, max_run, run_len, rdv_bad;
  bit last_gnt;

  typedef struct {
    logic [15:0] w;
    logic [31:0] d;
    int          n;
    int          a0;
    logic [31:0] v;
    bit          ign;
    int          rb;
  } vec_t;

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Spec-level decode: number of writes, first address, value, ignored flag.
  task automatic model(input logic [15:0] w, input logic [31:0] d,
                       output int n, output int a0, output logic [31:0] v, output bit ign);
    logic [4:0] op;
    op = w[15:11];
    n = 0; a0 = 0; v = '0; ign = 1'b0;
    if (op == 5'b11000 || (op == 5'b11001 && w[5])) begin
      n = 8;
    end else if (op == 5'b11001) begin
      n = 1; a0 = int'(w[8:6]);
    end else if (op == 5'b10001) begin
      n = 1; a0 = int'(w[8:6]); v = d;
    end else begin
      ign = 1'b1;
    end
  endtask

  task automatic upd_rd(input bit rnd);
    if (rd_req && last_gnt) rd_req = 1'b0;
    if (rnd && !rd_req && ($urandom_range(0, 3) != 0)) begin
      rd_req = 1'b1;
      rd_layer = 3'($urandom_range(0, 7));
    end
  endtask

  // Issue one command and record everything the RAM port does until done.
  task automatic run_cmd(input logic [15:0] w, input logic [31:0] d, input bit rnd, input bit ign);
    bit prev_gnt;
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    done_cyc = -1; done_cnt = 0; ign_cyc = -1; ign_cnt = 0; busy_bad = 0;
    busy_hi = 0; ready_lo = 0; mem_en_cnt = 0; max_run = 0; run_len = 0; rdv_bad = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_word = w; cmd_data = d;
    upd_rd(rnd);
    @(negedge clk);
    chk_eq("accept_ready", cmd_ready, 1);
    prev_gnt = rd_gnt; last_gnt = rd_gnt;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      upd_rd(rnd);
      @(negedge clk);
      last_gnt = rd_gnt;
      if (rd_valid !== prev_gnt) rdv_bad++;
      prev_gnt = rd_gnt;
      if (mif.mem_en) mem_en_cnt++;
      if (mif.mem_en && mif.mem_we) begin
        wq_addr.push_back(int'(mif.mem_addr));
        wq_data.push_back(mif.mem_wdata);
        wq_cyc.push_back(k);
      end
      if (busy && rd_gnt) run_len++; else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (busy) busy_hi++;
      if (!cmd_ready) ready_lo++;
      if (!ign && ((!done && !busy) || (done && busy))) busy_bad++;
      if (cmd_ignored) begin ign_cnt++; ign_cyc = k; end
      if (done) begin done_cnt++; done_cyc = k; break; end
      if (ign && k == 3) break;
    end
    for (int j = 0; j < 20 && rd_req && !last_gnt; j++) begin
      @(posedge clk); #1;
      @(negedge clk);
      last_gnt = rd_gnt;
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
    last_gnt = 1'b0;
  endtask

  task automatic check_cmd(input string nm, input int n, input int a0, input logic [31:0] v,
                           input bit ign, input bit exact);
    chk_eq({nm, "_nwr"}, wq_addr.size(), n);
    for (int i = 0; i < wq_addr.size() && i < n; i++) begin
      chk_eq({nm, "_waddr"}, wq_addr[i], a0 + i);
      chk_eq({nm, "_wdata"}, wq_data[i], v);
      if (exact) chk_eq({nm, "_wcyc"}, wq_cyc[i], i + 1);
    end
    if (ign) begin
      chk_eq({nm, "_ign_cnt"}, ign_cnt, 1);
      chk_eq({nm, "_ign_cyc"}, ign_cyc, 1);
      chk_eq({nm, "_no_done"}, done_cnt, 0);
      chk_eq({nm, "_no_busy"}, busy_hi, 0);
      chk_eq({nm, "_ready_kept"}, ready_lo, 0);
      if (exact) chk_eq({nm, "_no_mem_en"}, mem_en_cnt, 0);
    end else begin
      chk_eq({nm, "_no_ign"}, ign_cnt, 0);
      chk_eq({nm, "_done_cnt"}, done_cnt, 1);
      if (exact) chk_eq({nm, "_done_cyc"}, done_cyc, n + 1);
      else if (wq_cyc.size() > 0) chk_eq({nm, "_done_after_wr"}, done_cyc, wq_cyc[$] + 1);
      chk_eq({nm, "_busy"}, busy_bad, 0);
    end
    chk_eq({nm, "_starve_ok"}, (max_run <= STARVE_MAX), 1);
    chk_eq({nm, "_rd_valid"}, rdv_bad, 0);
    for (int i = 0; i < n; i++) exp_mem[(a0 + i) % 8] = v;
  endtask

  task automatic read_chk(input int l);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    rd_req = 1'b1; rd_layer = 3'(l);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rd_gnt) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk_eq("rd_gnt_seen", got, 1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    chk_eq("rd_valid", rd_valid, 1);
    chk_eq($sformatf("rd_data_l%0d", l), rd_data, exp_mem[l]);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk_eq({nm, "_cmd_ready"}, cmd_ready, 1);
    chk_eq({nm, "_busy"}, busy, 0);
    chk_eq({nm, "_done"}, done, 0);
    chk_eq({nm, "_ignored"}, cmd_ignored, 0);
    chk_eq({nm, "_rd_gnt"}, rd_gnt, 0);
    chk_eq({nm, "_rd_valid"}, rd_valid, 0);
    chk_eq({nm, "_rd_data"}, rd_data, 0);
    chk_eq({nm, "_mem_en"}, mif.mem_en, 0);
    chk_eq({nm, "_mem_we"}, mif.mem_we, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    int n, a0;
    logic [31:0] v;
    bit ign;
    logic [15:0] w;
    logic [31:0] d;
    int s_gnt [7] = '{1, 1, 1, 1, 1, 0, 1};
    int s_we  [7] = '{0, 0, 0, 0, 0, 1, 0};
    int s_dn  [7] = '{0, 0, 0, 0, 0, 0, 1};

    for (int i = 0; i < 8; i++) exp_mem[i] = '0;

    // Reset state.
    @(negedge clk); @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk); #1; rst_n = 1'b1;

    // Table-driven commands, no reads during the operation.
    tbl[0] = '{16'hC000, 32'h0,        8, 0, 32'h0,        1'b0, -1};
    tbl[1] = '{16'h8940, 32'hDEADBEEF, 1, 5, 32'hDEADBEEF, 1'b0, 5};
    tbl[2] = '{16'hC820, 32'h0,        8, 0, 32'h0,        1'b0, 5};
    tbl[3] = '{16'h0000, 32'h12345678, 0, 0, 32'h0,        1'b1, 5};
    tbl[4] = '{16'h8A80, 32'hCAFEF00D, 1, 2, 32'hCAFEF00D, 1'b0, 2};
    for (int t = 0; t < 5; t++) begin
      run_cmd(tbl[t].w, tbl[t].d, 1'b0, tbl[t].ign);
      check_cmd($sformatf("tbl%0d", t), tbl[t].n, tbl[t].a0, tbl[t].v, tbl[t].ign, 1'b1);
      if (tbl[t].rb >= 0) read_chk(tbl[t].rb);
    end

    // Fill all layers, then single-clear layer 3.
    for (int l = 0; l < 8; l++) begin
      w = {5'b10001, 2'b00, 3'(l), 6'b0};
      run_cmd(w, 32'h11111111, 1'b0, 1'b0);
      check_cmd("fill", 1, l, 32'h11111111, 1'b0, 1'b1);
    end
    run_cmd(16'hC8C0, 32'hFFFFFFFF, 1'b0, 1'b0);
    check_cmd("single_clr", 1, 3, 32'h0, 1'b0, 1'b1);
    for (int l = 0; l < 8; l++) read_chk(l);

    // Starvation: reads requested continuously during a write.
    @(posedge clk); #1;
    rd_req = 1'b1; rd_layer = 3'd6;
    cmd_valid = 1'b1; cmd_word = 16'h8940; cmd_data = 32'hA5A50F0F;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin @(posedge clk); #1; cmd_valid = 1'b0; end
      @(negedge clk);
      chk_eq($sformatf("starve_gnt_k%0d", k), rd_gnt, s_gnt[k]);
      chk_eq($sformatf("starve_we_k%0d", k), mif.mem_we, s_we[k]);
      chk_eq($sformatf("starve_done_k%0d", k), done, s_dn[k]);
      if (s_we[k] == 1) begin
        chk_eq("starve_waddr", mif.mem_addr, 5);
        chk_eq("starve_wdata", mif.mem_wdata, 32'hA5A50F0F);
      end
    end
    @(posedge clk); #1; rd_req = 1'b0;
    exp_mem[5] = 32'hA5A50F0F;
    read_chk(5);

    // Reset in the middle of a clear-all.
    run_cmd(16'h88C0, 32'h11111111, 1'b0, 1'b0);
    check_cmd("refill3", 1, 3, 32'h11111111, 1'b0, 1'b1);
    run_cmd(16'h8940, 32'h11111111, 1'b0, 1'b0);
    check_cmd("refill5", 1, 5, 32'h11111111, 1'b0, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_word = 16'hC000;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1; cmd_valid = 1'b0;
      @(negedge clk);
      chk_eq($sformatf("midclr_we_k%0d", k), mif.mem_we, 1);
      chk_eq($sformatf("midclr_addr_k%0d", k), mif.mem_addr, k - 1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_eq("midrst_no_done", done, 0);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int l = 0; l < 3; l++) exp_mem[l] = '0;
    for (int l = 0; l < 8; l++) read_chk(l);

    // Randomized commands with random concurrent reads.
    for (int it = 0; it < 25; it++) begin
      d = $urandom;
      w = 16'($urandom);
      case ($urandom_range(0, 3))
        0: w[15:11] = 5'b10001;
        1: w[15:11] = 5'b11001;
        2: w[15:11] = 5'b11000;
        default: if (w[15:11] == 5'b10001 || w[15:11] == 5'b11001 || w[15:11] == 5'b11000)
                   w[15:11] = 5'b00000;
      endcase
      model(w, d, n, a0, v, ign);
      run_cmd(w, d, 1'b1, ign);
      check_cmd($sformatf("rnd%0d", it), n, a0, v, ign, 1'b0);
      read_chk($urandom_range(0, 7));
      read_chk($urandom_range(0, 7));
    end
    for (int l = 0; l < 8; l++) read_chk(l);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
